pong_match_ctrl: RTL
====================

Name: pong_match_ctrl

Overview:
- Parametrised match/scoring controller for the pong game.
- Replaces the ad-hoc score registers and win-condition logic in the top level.
- Takes point events from ball logic and the frame tick from the VGA timing path; sequences serve delay, play, pause and game-over.
- Outputs per-player scores, ball run/reset controls, serve direction and winner. Supports 2–4 players and win-by-margin rules.

Parameters:
- NUM_PLAYERS, 2, number of players (2..4).
- SCORE_W, 6, bits per score counter.
- WIN_SCORE, 5, minimum score needed to win (1..2^SCORE_W-1).
- WIN_BY, 1, required lead over every other player (1 = plain first-to-WIN_SCORE).
- SERVE_DELAY, 60, frames the ball is held before each serve (>=1).
- PID_W, 2, width of player index.

Ports:
- clk  in  1  system clock (25 MHz pixel clock domain).
- reset  in  1  asynchronous, active-low reset.
- refresh_tick  in  1  one-cycle frame pulse.
- start  in  1  one-cycle pulse: begin match / restart after game over.
- pause  in  1  one-cycle pulse: toggle pause.
- point_valid  in  1  one-cycle pulse: a point was scored.
- point_player  in  PID_W  index of scoring player, sampled with point_valid.
- scores  out  NUM_PLAYERS*SCORE_W  packed scores; player i at [i*SCORE_W +: SCORE_W].
- ball_run  out  1  ball may move.
- ball_reset  out  1  one-cycle pulse: recentre ball.
- serve_player  out  PID_W  player the next serve travels toward.
- state  out  3  FSM state encoding.
- game_over  out  1  match finished.
- winner  out  PID_W  winning player index; valid while game_over.

Behaviour:
- Reset (reset==0, async): state=IDLE, all scores=0, ball_run=0, ball_reset=0, serve_player=0, game_over=0, winner=0, frame counter=0.
- State encodings: IDLE=0, SERVE=1, PLAY=2, PAUSED=3, OVER=4.
- IDLE:
  - start -> SERVE.
  - ball_reset pulses in the cycle the state register becomes SERVE (1-cycle latency from start).
- SERVE:
  - Frame counter clears on entry and increments on each refresh_tick.
  - When it reaches SERVE_DELAY -> PLAY.
  - pause -> PAUSED; the counter is held, not cleared.
- PLAY:
  - ball_run=1 (registered; high exactly while state==PLAY).
  - On point_valid with point_player < NUM_PLAYERS: increment that score (saturates at 2^SCORE_W-1), then evaluate the win check on the updated scores in the same cycle.
  - Win check: updated score >= WIN_SCORE and (updated score − every other score) >= WIN_BY.
  - Win -> OVER; winner=point_player; game_over=1.
  - No win -> SERVE; ball_reset pulse; serve_player = (point_player+1) mod NUM_PLAYERS.
  - pause with no point_valid -> PAUSED.
- PAUSED:
  - ball_run=0; the return state (SERVE or PLAY) is remembered.
  - pause -> return to the remembered state. The serve counter resumes; no ball_reset is issued.
  - point_valid is ignored.
- OVER:
  - ball_run=0; scores, winner and game_over are held.
  - start -> clear scores, game_over=0, serve_player=0 -> SERVE, with ball_reset pulse.
- Ignored events:
  - point_valid outside PLAY.
  - point_player >= NUM_PLAYERS (no score change, no state change).
  - start outside IDLE and OVER.
  - pause in IDLE and OVER.
- Simultaneous events:
  - point_valid and pause in the same PLAY cycle: the point is processed and the pause is dropped.
  - start and pause together in IDLE/OVER: start wins.
- Margin and saturation:
  - Subtraction is done at SCORE_W+1 bits signed; a negative lead fails the check.
  - A saturated score still participates in the win check.
- Reset mid-match: immediate return to IDLE with everything cleared. No ball_reset pulse is generated by reset.

Test Plan:
1. NUM_PLAYERS=2, WIN_SCORE=5, WIN_BY=1, SERVE_DELAY=3. Drive start, then 3 refresh_ticks -> state SERVE→PLAY after the 3rd tick; ball_reset pulses once, 1 cycle after start.
2. Five points to player 1 with serves between -> scores=5/0 and state=OVER after the 5th; winner=1, game_over=1, ball_run=0; start then clears both scores to 0.
3. WIN_BY=2: drive scores to 4/4, player 0 scores (5/4) -> SERVE, not OVER; player 0 scores again (6/4) -> OVER with winner=0.
4. pause after 1 tick in SERVE, 5 ticks while PAUSED, then pause again -> counter resumes at 1; PLAY is reached 2 ticks later; no extra ball_reset.
5. point_valid with point_player=3 when NUM_PLAYERS=2 -> no change; point_valid in IDLE/PAUSED -> no change; point_valid+pause in the same PLAY cycle -> score increments, state SERVE.
6. Assert reset low during PLAY with scores 3/2 -> all outputs at reset values immediately (async); after release, state IDLE.

Source files
------------

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: match sequencing and scoring for pong (serve delay, play, pause, game over)
module pong_match_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 6,
  parameter int WIN_SCORE   = 5,
  parameter int WIN_BY      = 1,
  parameter int SERVE_DELAY = 60,
  parameter int PID_W       = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           refresh_tick,
  input  logic                           start,
  input  logic                           pause,
  input  logic                           point_valid,
  input  logic [PID_W-1:0]               point_player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] scores,
  output logic                           ball_run,
  output logic                           ball_reset,
  output logic [PID_W-1:0]               serve_player,
  output logic [2:0]                     state,
  output logic                           game_over,
  output logic [PID_W-1:0]               winner
);
  localparam int CNT_W = $clog2(SERVE_DELAY + 1);
  localparam int SW1 = SCORE_W + 1;
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(SERVE_DELAY - 1);
  localparam logic [SCORE_W-1:0] L_MAX = '1;
  localparam logic [SCORE_W-1:0] L_WIN = SCORE_W'(WIN_SCORE);
  localparam logic signed [SCORE_W:0] L_BY = SW1'(WIN_BY);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SERVE  = 3'd1,
    PLAY   = 3'd2,
    PAUSED = 3'd3,
    OVER   = 3'd4
  } st_t;

  st_t                 r_state;
  st_t                 r_ret;
  logic [SCORE_W-1:0]  r_score [NUM_PLAYERS];
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ball_run;
  logic                r_ball_reset;
  logic [PID_W-1:0]    r_serve;
  logic                r_game_over;
  logic [PID_W-1:0]    r_winner;

  logic                w_pp_ok;
  logic                w_win;
  logic [SCORE_W-1:0]  w_upd;
  logic signed [SCORE_W:0] w_diff;
  logic [PID_W-1:0]    w_next_serve;

  // Saturating score update for the scoring player and the lead check against every other player
  always_comb begin
    w_pp_ok = 32'(point_player) < NUM_PLAYERS;
    w_upd = '0;
    w_diff = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (32'(point_player) == i) w_upd = (r_score[i] == L_MAX) ? r_score[i] : r_score[i] + SCORE_W'(1);
    w_win = w_pp_ok && (w_upd >= L_WIN);
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (32'(point_player) != i) begin
        w_diff = {1'b0, w_upd} - {1'b0, r_score[i]};
        if (w_diff < L_BY) w_win = 1'b0;
      end
    w_next_serve = (32'(point_player) == NUM_PLAYERS - 1) ? '0 : point_player + PID_W'(1);
  end

  // Pack the per-player score registers onto the output bus
  always_comb begin
    scores = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) scores[i*SCORE_W +: SCORE_W] = r_score[i];
  end

  // Match FSM: serve countdown, play, pause with remembered return state, game over
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ret        <= SERVE;
      r_cnt        <= '0;
      r_ball_run   <= 1'b0;
      r_ball_reset <= 1'b0;
      r_serve      <= '0;
      r_game_over  <= 1'b0;
      r_winner     <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
    end else begin
      r_ball_reset <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state      <= SERVE;
            r_cnt        <= '0;
            r_ball_reset <= 1'b1;
          end
        end
        SERVE: begin
          if (pause) begin
            r_state <= PAUSED;
            r_ret   <= SERVE;
          end else if (refresh_tick) begin
            if (r_cnt == L_LAST) begin
              r_state    <= PLAY;
              r_ball_run <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        PLAY: begin
          if (point_valid && w_pp_ok) begin
            for (int i = 0; i < NUM_PLAYERS; i++)
              if (32'(point_player) == i) r_score[i] <= w_upd;
            r_ball_run <= 1'b0;
            if (w_win) begin
              r_state     <= OVER;
              r_game_over <= 1'b1;
              r_winner    <= point_player;
            end else begin
              r_state      <= SERVE;
              r_cnt        <= '0;
              r_ball_reset <= 1'b1;
              r_serve      <= w_next_serve;
            end
          end else if (pause && !point_valid) begin
            r_state    <= PAUSED;
            r_ret      <= PLAY;
            r_ball_run <= 1'b0;
          end
        end
        PAUSED: begin
          if (pause) begin
            r_state    <= r_ret;
            r_ball_run <= (r_ret == PLAY);
          end
        end
        OVER: begin
          if (start) begin
            for (int i = 0; i < NUM_PLAYERS; i++) r_score[i] <= '0;
            r_game_over  <= 1'b0;
            r_serve      <= '0;
            r_state      <= SERVE;
            r_cnt        <= '0;
            r_ball_reset <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign state        = r_state;
  assign ball_run     = r_ball_run;
  assign ball_reset   = r_ball_reset;
  assign serve_player = r_serve;
  assign game_over    = r_game_over;
  assign winner       = r_winner;
endmodule
